// File: rtl/upg_sequencer_if.sv
// Signal bundle between the UART program-upload loader, the memories and the sequencer.
// The slave modport is the sequencer's view; master is the driving side.
interface upg_sequencer_if;
  logic        start_pg;
  logic        upg_wen_i;
  logic [14:0] upg_adr_i;
  logic        upg_done_i;
  logic        upg_rst_o;
  logic        cpu_rst_o;
  logic        rom_wen_o;
  logic        dmem_wen_o;
  logic [13:0] rom_cnt_o;
  logic [13:0] dmem_cnt_o;
  logic [2:0]  state_o;
  logic [1:0]  err_o;

  modport slave (
    input  start_pg, upg_wen_i, upg_adr_i, upg_done_i,
    output upg_rst_o, cpu_rst_o, rom_wen_o, dmem_wen_o,
           rom_cnt_o, dmem_cnt_o, state_o, err_o
  );

  modport master (
    output start_pg, upg_wen_i, upg_adr_i, upg_done_i,
    input  upg_rst_o, cpu_rst_o, rom_wen_o, dmem_wen_o,
           rom_cnt_o, dmem_cnt_o, state_o, err_o
  );
endinterface

// File: rtl/upg_sequencer.sv
// Program-upload sequencer: holds the CPU in reset while the UART loader writes ROM/dmem,
// routes loader writes to the right memory, counts them, and aborts on idle timeout or empty upload.
module upg_sequencer #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000,
  parameter logic [7:0]  DRAIN_CYCLES   = 8'd16
) (
  input  logic           clock,
  input  logic           rst_n,
  upg_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_ARM   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  state_t      state_q;
  logic        upg_rst_q;
  logic        cpu_rst_q;
  logic [1:0]  err_q;
  logic [13:0] rom_cnt_q;
  logic [13:0] dmem_cnt_q;
  logic [23:0] idle_q;
  logic [7:0]  drain_q;

  logic [13:0] rom_cnt_d;
  logic [13:0] dmem_cnt_d;
  logic        loading;
  logic        wen_ok;
  logic        timeout_hit;
  logic        drain_last;
  logic        unused_adr;

  assign loading     = (state_q == ST_ARM) || (state_q == ST_LOAD);
  assign wen_ok      = bus.upg_wen_i & loading;
  assign timeout_hit = (idle_q == TIMEOUT_CYCLES - 24'd1);
  // A zero drain length still spends one cycle in DRAIN rather than wrapping.
  assign drain_last  = (({1'b0, drain_q} + 9'd1) >= {1'b0, DRAIN_CYCLES});

  assign rom_cnt_d  = (rom_cnt_q  == 14'h3FFF) ? rom_cnt_q  : rom_cnt_q  + 14'd1;
  assign dmem_cnt_d = (dmem_cnt_q == 14'h3FFF) ? dmem_cnt_q : dmem_cnt_q + 14'd1;

  // Write enables follow the state register directly so an async reset kills them at once.
  assign bus.rom_wen_o  = wen_ok & ~bus.upg_adr_i[14];
  assign bus.dmem_wen_o = wen_ok &  bus.upg_adr_i[14];
  assign unused_adr     = ^bus.upg_adr_i[13:0];

  assign bus.upg_rst_o  = upg_rst_q;
  assign bus.cpu_rst_o  = cpu_rst_q;
  assign bus.err_o      = err_q;
  assign bus.rom_cnt_o  = rom_cnt_q;
  assign bus.dmem_cnt_o = dmem_cnt_q;
  assign bus.state_o    = state_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      upg_rst_q  <= 1'b1;
      cpu_rst_q  <= 1'b0;
      err_q      <= 2'b00;
      rom_cnt_q  <= 14'd0;
      dmem_cnt_q <= 14'd0;
      idle_q     <= 24'd0;
      drain_q    <= 8'd0;
    end else begin
      if (wen_ok && !bus.upg_adr_i[14]) rom_cnt_q  <= rom_cnt_d;
      if (wen_ok &&  bus.upg_adr_i[14]) dmem_cnt_q <= dmem_cnt_d;

      case (state_q)
        ST_RUN, ST_ERR: begin
          if (bus.start_pg) begin
            state_q    <= ST_ARM;
            upg_rst_q  <= 1'b0;
            cpu_rst_q  <= 1'b1;
            err_q      <= 2'b00;
            rom_cnt_q  <= 14'd0;
            dmem_cnt_q <= 14'd0;
            idle_q     <= 24'd0;
          end
        end
        ST_ARM, ST_LOAD: begin
          // Done has priority over both a fresh write and a simultaneous timeout.
          if (bus.upg_done_i) begin
            upg_rst_q <= 1'b1;
            if (wen_ok || state_q == ST_LOAD) begin
              state_q <= ST_DRAIN;
              drain_q <= 8'd0;
            end else begin
              state_q <= ST_ERR;
              err_q   <= 2'b10;
            end
          end else if (wen_ok) begin
            state_q <= ST_LOAD;
            idle_q  <= 24'd0;
          end else if (timeout_hit) begin
            state_q   <= ST_ERR;
            err_q     <= 2'b01;
            upg_rst_q <= 1'b1;
          end else begin
            idle_q <= idle_q + 24'd1;
          end
        end
        ST_DRAIN: begin
          if (drain_last) begin
            state_q   <= ST_RUN;
            cpu_rst_q <= 1'b0;
          end else begin
            drain_q <= drain_q + 8'd1;
          end
        end
        default: begin
          state_q   <= ST_RUN;
          upg_rst_q <= 1'b1;
          cpu_rst_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_upg_sequencer.sv
// Bench for upg_sequencer: directed tables and sequences for the upload scenarios,
// then long randomized traffic compared against a cycle-timestamp reference model.
module tb_upg_sequencer;

  localparam int TMO = 100;
  localparam int DRN = 16;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  upg_sequencer_if bus ();

  upg_sequencer #(
    .TIMEOUT_CYCLES(24'd100),
    .DRAIN_CYCLES  (8'd16)
  ) dut (
    .clock(clock),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        s;
    logic        w;
    logic [14:0] a;
    logic        d;
    logic        rw;
    logic        dw;
    int          st;
    int          rc;
    int          dc;
    int          er;
    int          ur;
    int          cr;
  } row_t;

  row_t tab_a[9];
  row_t tab_b[7];

  // Reference model: phase plus edge timestamps of the last timer-restarting event.
  int m_phase, m_rom, m_dmem, m_err, m_edge, m_last;

  function automatic row_t mk(input logic s, w, input logic [14:0] a, input logic d,
                              input logic rw, dw, input int st, rc, dc, er, ur, cr);
    row_t r;
    r.s = s; r.w = w; r.a = a; r.d = d; r.rw = rw; r.dw = dw;
    r.st = st; r.rc = rc; r.dc = dc; r.er = er; r.ur = ur; r.cr = cr;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic s, w, input logic [14:0] a, input logic d);
    bus.start_pg   = s;
    bus.upg_wen_i  = w;
    bus.upg_adr_i  = a;
    bus.upg_done_i = d;
  endtask

  task automatic check_regs(input string tag, input int st, rc, dc, er, ur, cr);
    chk({tag, ".state"}, bus.state_o, st);
    chk({tag, ".rom_cnt"}, bus.rom_cnt_o, rc);
    chk({tag, ".dmem_cnt"}, bus.dmem_cnt_o, dc);
    chk({tag, ".err"}, bus.err_o, er);
    chk({tag, ".upg_rst"}, bus.upg_rst_o, ur);
    chk({tag, ".cpu_rst"}, bus.cpu_rst_o, cr);
  endtask

  task automatic apply_row(input string tag, input row_t r);
    @(negedge clock);
    drive(r.s, r.w, r.a, r.d);
    #1;
    chk({tag, ".rom_wen"}, bus.rom_wen_o, r.rw);
    chk({tag, ".dmem_wen"}, bus.dmem_wen_o, r.dw);
    @(posedge clock);
    #1;
    check_regs(tag, r.st, r.rc, r.dc, r.er, r.ur, r.cr);
    $display("%s in s=%0b w=%0b a=%h d=%0b -> state=%0d rom=%0d dmem=%0d err=%0d",
             tag, r.s, r.w, r.a, r.d, bus.state_o, bus.rom_cnt_o, bus.dmem_cnt_o, bus.err_o);
  endtask

  task automatic model_reset();
    m_phase = 0; m_rom = 0; m_dmem = 0; m_err = 0; m_edge = 0; m_last = 0;
  endtask

  task automatic model_step(input logic s, w, input logic [14:0] a, input logic d);
    bit acc;
    m_edge++;
    acc = (m_phase == 1 || m_phase == 2) && w;
    if (acc && !a[14]) m_rom  = (m_rom  < 16383) ? m_rom  + 1 : 16383;
    if (acc &&  a[14]) m_dmem = (m_dmem < 16383) ? m_dmem + 1 : 16383;
    case (m_phase)
      0, 4: if (s) begin
        m_phase = 1; m_rom = 0; m_dmem = 0; m_err = 0; m_last = m_edge;
      end
      1, 2: begin
        if (d) begin
          if (acc || m_phase == 2) begin m_phase = 3; m_last = m_edge; end
          else begin m_phase = 4; m_err = 2; end
        end else if (acc) begin
          m_phase = 2; m_last = m_edge;
        end else if (m_edge - m_last == TMO) begin
          m_phase = 4; m_err = 1;
        end
      end
      3: if (m_edge - m_last == DRN) m_phase = 0;
      default: ;
    endcase
  endtask

  task automatic rcycle(input logic s, w, input logic [14:0] a, input logic d);
    bit act;
    @(negedge clock);
    drive(s, w, a, d);
    #1;
    act = (m_phase == 1 || m_phase == 2);
    chk("rnd.rom_wen", bus.rom_wen_o, act && w && !a[14]);
    chk("rnd.dmem_wen", bus.dmem_wen_o, act && w && a[14]);
    model_step(s, w, a, d);
    @(posedge clock);
    #1;
    check_regs("rnd", m_phase, m_rom, m_dmem, m_err,
               (m_phase == 1 || m_phase == 2) ? 0 : 1, (m_phase == 0) ? 0 : 1);
  endtask

  task automatic do_reset();
    @(negedge clock);
    drive(1'b0, 1'b0, 15'h0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    tab_a[0] = mk(0, 1, 15'h0000, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tab_a[1] = mk(0, 1, 15'h4000, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tab_a[2] = mk(1, 0, 15'h0000, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    tab_a[3] = mk(0, 1, 15'h0000, 0, 1, 0, 2, 1, 0, 0, 0, 1);
    tab_a[4] = mk(0, 1, 15'h0001, 0, 1, 0, 2, 2, 0, 0, 0, 1);
    tab_a[5] = mk(0, 1, 15'h0002, 0, 1, 0, 2, 3, 0, 0, 0, 1);
    tab_a[6] = mk(0, 1, 15'h4000, 0, 0, 1, 2, 3, 1, 0, 0, 1);
    tab_a[7] = mk(0, 1, 15'h4001, 0, 0, 1, 2, 3, 2, 0, 0, 1);
    tab_a[8] = mk(0, 0, 15'h0000, 1, 0, 0, 3, 3, 2, 0, 1, 1);

    tab_b[0] = mk(1, 0, 15'h0000, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    tab_b[1] = mk(0, 0, 15'h0000, 1, 0, 0, 4, 0, 0, 2, 1, 1);
    tab_b[2] = mk(0, 1, 15'h0000, 0, 0, 0, 4, 0, 0, 2, 1, 1);
    tab_b[3] = mk(1, 0, 15'h0000, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    tab_b[4] = mk(0, 1, 15'h4005, 0, 0, 1, 2, 0, 1, 0, 0, 1);
    tab_b[5] = mk(0, 1, 15'h4005, 1, 0, 1, 3, 0, 2, 0, 1, 1);
    tab_b[6] = mk(1, 0, 15'h0000, 0, 0, 0, 3, 0, 2, 0, 1, 1);

    drive(1'b0, 1'b0, 15'h0, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    check_regs("reset", 0, 0, 0, 0, 1, 0);
    @(negedge clock);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) apply_row($sformatf("upload.r%0d", i), tab_a[i]);

    // Drain hold: 15 more cycles in DRAIN, then release on the 16th edge.
    for (int i = 1; i <= DRN; i++) begin
      @(negedge clock);
      drive(1'b0, 1'b0, 15'h0, 1'b0);
      @(posedge clock);
      #1;
      chk($sformatf("drain.c%0d.state", i), bus.state_o, (i < DRN) ? 3 : 0);
      chk($sformatf("drain.c%0d.cpu_rst", i), bus.cpu_rst_o, (i < DRN) ? 1 : 0);
    end
    $display("drain done: state=%0d cpu_rst=%0d", bus.state_o, bus.cpu_rst_o);

    for (int i = 0; i < 7; i++) apply_row($sformatf("err_coinc.r%0d", i), tab_b[i]);

    // Idle timeout after a single write.
    do_reset();
    rcycle(1'b1, 1'b0, 15'h0, 1'b0);
    rcycle(1'b0, 1'b1, 15'h0010, 1'b0);
    repeat (TMO - 1) rcycle(1'b0, 1'b0, 15'h0, 1'b0);
    chk("timeout.pre_state", bus.state_o, 2);
    rcycle(1'b0, 1'b0, 15'h0, 1'b0);
    chk("timeout.state", bus.state_o, 4);
    chk("timeout.err", bus.err_o, 1);
    repeat (5) rcycle(1'b0, 1'b0, 15'h0, 1'b0);
    chk("timeout.cpu_rst_held", bus.cpu_rst_o, 1);
    $display("timeout: state=%0d err=%0d cpu_rst=%0d", bus.state_o, bus.err_o, bus.cpu_rst_o);

    // Asynchronous reset in the middle of a load cycle.
    do_reset();
    rcycle(1'b1, 1'b0, 15'h0, 1'b0);
    rcycle(1'b0, 1'b1, 15'h0003, 1'b0);
    @(negedge clock);
    drive(1'b0, 1'b1, 15'h0004, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst.state", bus.state_o, 0);
    chk("async_rst.upg_rst", bus.upg_rst_o, 1);
    chk("async_rst.cpu_rst", bus.cpu_rst_o, 0);
    chk("async_rst.rom_wen", bus.rom_wen_o, 0);
    chk("async_rst.rom_cnt", bus.rom_cnt_o, 0);
    $display("async reset: state=%0d upg_rst=%0d cpu_rst=%0d", bus.state_o, bus.upg_rst_o, bus.cpu_rst_o);
    @(negedge clock);
    drive(1'b0, 1'b0, 15'h0, 1'b0);
    rst_n = 1'b1;
    model_reset();

    // Saturate the ROM counter.
    rcycle(1'b1, 1'b0, 15'h0, 1'b0);
    for (int i = 0; i < 16400; i++)
      rcycle(1'b0, 1'b1, {1'b0, 14'($urandom)}, 1'b0);
    chk("saturate.rom_cnt", bus.rom_cnt_o, 14'h3FFF);
    $display("saturate: rom_cnt=%h", bus.rom_cnt_o);

    // Randomized traffic with varying write density so timeouts also occur.
    do_reset();
    for (int seg = 0; seg < 40; seg++) begin
      int pct;
      int bad0;
      bad0 = n_bad;
      case ($urandom_range(2))
        0: pct = 0;
        1: pct = 10;
        default: pct = 60;
      endcase
      for (int c = 0; c < 100; c++)
        rcycle($urandom_range(19) == 0, $urandom_range(99) < pct,
               15'($urandom), $urandom_range(39) == 0);
      $display("random seg %0d pct=%0d state=%0d rom=%0d dmem=%0d err=%0d new_bad=%0d",
               seg, pct, bus.state_o, bus.rom_cnt_o, bus.dmem_cnt_o, bus.err_o, n_bad - bad0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
